link_sync_ctrl: RTL and testbench
=================================

LINK_SYNC_CTRL -- requirements
Module: link_sync_ctrl

Interface
REQ-001 Parameter COMMA, 8'hBC, idle/comma byte value.
REQ-002 Parameter SYNC_CNT, 4, consecutive commas required to declare link active.
REQ-003 Parameter SLIP_TRIG, 8, consecutive non-comma bytes in SEARCH before a bit-slip request.
REQ-004 Parameter SLIP_WAIT, 2, valid bytes ignored after a bit-slip request.
REQ-005 Parameter MAX_RUN, 32, maximum consecutive non-comma bytes tolerated in LOCKED.
REQ-006 Port clk_4f, input, 1, byte clock; the single clock; all logic on its rising edge.
REQ-007 Port reset, input, 1, synchronous, active-high reset.
REQ-008 Port byte_in, input, 8, parallel byte from the serial-to-parallel datapath.
REQ-009 Port byte_valid, input, 1, byte_in is a new byte this cycle.
REQ-010 Port bitslip, output, 1, one-cycle request to shift datapath byte alignment by one bit.
REQ-011 Port active, output, 1, link synchronized.
REQ-012 Port data_out, output, 8, forwarded payload byte.
REQ-013 Port valid_out, output, 1, data_out holds a payload byte this cycle.
REQ-014 Port slip_count, output, 4, saturating count of bit-slips since reset.

Function
REQ-015 All outputs shall be registered; a byte accepted in cycle N shall affect outputs in cycle N+1.
REQ-016 The FSM shall have exactly the states SEARCH, SLIP_WAIT, CHECK and LOCKED.
REQ-017 A cycle with byte_valid=0 shall change no state or counter, and valid_out and bitslip shall be 0.
REQ-018 SEARCH: a comma shall go to CHECK with comma count 1; a non-comma shall increment the miss counter.
REQ-019 SEARCH: the SLIP_TRIG-th consecutive non-comma shall pulse bitslip for one cycle, clear the miss counter, increment slip_count (saturating at 15) and go to SLIP_WAIT.
REQ-020 SLIP_WAIT: the controller shall discard SLIP_WAIT valid bytes regardless of value, then return to SEARCH.
REQ-021 CHECK: a comma shall increment the comma count; on reaching SYNC_CNT the FSM shall go to LOCKED and set active.
REQ-022 CHECK: a non-comma shall clear the comma count and return to SEARCH without a bit-slip.
REQ-023 LOCKED: a non-comma byte shall be copied to data_out with valid_out=1 for one cycle.
REQ-024 LOCKED: a comma byte shall produce valid_out=0, leave data_out unchanged and clear the run counter.
REQ-025 LOCKED: each non-comma byte shall increment the run counter; the byte that makes it exceed MAX_RUN shall be discarded (valid_out=0), clear active and go to SEARCH.
REQ-026 active shall be 1 exactly while the FSM is in LOCKED.
REQ-027 Counters shall be sized to hold their parameter value without wrap; slip_count shall saturate rather than wrap.

Reset
REQ-028 When reset=1 at a clock edge, the controller shall go to SEARCH and clear all counters, taking precedence over byte_valid.
REQ-029 Reset values shall be bitslip=0, active=0, data_out=8'h00, valid_out=0 and slip_count=0.
REQ-030 Reset asserted in any state, including mid-lock, shall take effect at the next edge with no output glitch afterward.

Structure
REQ-031 COMMA, the default parameter values and the state encoding shall live in the shared package link_sync_pkg.
REQ-032 The saturating counters for miss, comma, run and slip shall use one sub-module, sync_sat_cnt (width parameter; increment, clear and saturate controls).

Verification
REQ-033 Reset, then four 8'hBC bytes: active=1 one cycle after the 4th comma, with no valid_out during the sequence.
REQ-034 Locked, then 16 bytes 8'h01..8'h10 followed by 8'hBC: valid_out=1 for 16 cycles with data_out matching each byte one cycle later, then valid_out=0 on the comma.
REQ-035 Three 8'hBC then 8'h55 then four 8'hBC: the sequence returns to SEARCH on 8'h55, with active=1 only after the final four commas and no bitslip.
REQ-036 Eight 8'h3C bytes from reset: bitslip=1 for exactly one cycle and slip_count=1; the next two bytes (8'hBC, 8'hBC) are ignored and the FSM is back in SEARCH.
REQ-037 Locked, then 33 non-comma bytes: bytes 1-32 are forwarded, byte 33 is dropped and active falls to 0.
REQ-038 Reset pulsed while LOCKED with byte_valid=1: next cycle active=0, valid_out=0, slip_count=0.

Source files
------------

// File: rtl/link_sync_pkg.sv
// Shared constants, state encoding and sizing helper for the link sync controller.
package link_sync_pkg;

  localparam logic [7:0]  COMMA_DEF     = 8'hBC;
  localparam int unsigned SYNC_CNT_DEF  = 4;
  localparam int unsigned SLIP_TRIG_DEF = 8;
  localparam int unsigned SLIP_WAIT_DEF = 2;
  localparam int unsigned MAX_RUN_DEF   = 32;
  localparam int unsigned SLIP_CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP_WAIT,
    ST_CHECK,
    ST_LOCKED
  } state_t;

  // Bits needed to hold 0..n without wrap.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_sat_cnt.sv
// Saturating up-counter with synchronous clear; shared by all controller counters.
module sync_sat_cnt #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk_4f) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/link_sync_ctrl.sv
// Comma-based byte alignment and link lock controller with payload forwarding.
module link_sync_ctrl
  import link_sync_pkg::*;
#(
  parameter logic [7:0]  COMMA     = COMMA_DEF,
  parameter int unsigned SYNC_CNT  = SYNC_CNT_DEF,
  parameter int unsigned SLIP_TRIG = SLIP_TRIG_DEF,
  parameter int unsigned SLIP_WAIT = SLIP_WAIT_DEF,
  parameter int unsigned MAX_RUN   = MAX_RUN_DEF
) (
  input  logic                  clk_4f,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  bitslip,
  output logic                  active,
  output logic [7:0]            data_out,
  output logic                  valid_out,
  output logic [SLIP_CNT_W-1:0] slip_count
);

  localparam int unsigned MISS_W  = cnt_width(SLIP_TRIG);
  localparam int unsigned COMMA_W = cnt_width(SYNC_CNT);
  localparam int unsigned RUN_W   = cnt_width(MAX_RUN);
  localparam int unsigned WAIT_W  = cnt_width(SLIP_WAIT);

  state_t state, state_next;

  logic [MISS_W-1:0]  miss_cnt;
  logic [COMMA_W-1:0] comma_cnt;
  logic [RUN_W-1:0]   run_cnt;
  logic [WAIT_W-1:0]  wait_cnt;

  logic miss_inc, miss_clr, comma_inc, comma_clr;
  logic run_inc, run_clr, wait_inc, wait_clr, slip_inc;
  logic slip_now, fwd;
  logic is_comma;

  assign is_comma = (byte_in == COMMA);

  always_ff @(posedge clk_4f) begin
    if (reset) state <= ST_SEARCH;
    else       state <= state_next;
  end

  // Comma count is kept at zero whenever the FSM sits in SEARCH, so the
  // first comma there only needs an increment to read as "count 1".
  always_comb begin
    state_next = state;
    if (byte_valid) begin
      unique case (state)
        ST_SEARCH: begin
          if (is_comma)                                  state_next = ST_CHECK;
          else if (miss_cnt == MISS_W'(SLIP_TRIG - 1))   state_next = ST_SLIP_WAIT;
        end
        ST_SLIP_WAIT: begin
          if (wait_cnt == WAIT_W'(SLIP_WAIT - 1))        state_next = ST_SEARCH;
        end
        ST_CHECK: begin
          if (!is_comma)                                 state_next = ST_SEARCH;
          else if (comma_cnt == COMMA_W'(SYNC_CNT - 1))  state_next = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (!is_comma && (run_cnt == RUN_W'(MAX_RUN))) state_next = ST_SEARCH;
        end
        default: state_next = ST_SEARCH;
      endcase
    end
  end

  always_comb begin
    miss_inc  = 1'b0;
    miss_clr  = 1'b0;
    comma_inc = 1'b0;
    comma_clr = 1'b0;
    run_inc   = 1'b0;
    run_clr   = 1'b0;
    wait_inc  = 1'b0;
    wait_clr  = 1'b0;
    slip_inc  = 1'b0;
    slip_now  = 1'b0;
    fwd       = 1'b0;
    if (byte_valid) begin
      unique case (state)
        ST_SEARCH: begin
          if (is_comma) begin
            comma_inc = 1'b1;
            miss_clr  = 1'b1;
          end else if (miss_cnt == MISS_W'(SLIP_TRIG - 1)) begin
            slip_now  = 1'b1;
            slip_inc  = 1'b1;
            miss_clr  = 1'b1;
          end else begin
            miss_inc  = 1'b1;
          end
        end
        ST_SLIP_WAIT: begin
          if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) wait_clr = 1'b1;
          else                                    wait_inc = 1'b1;
        end
        ST_CHECK: begin
          if (!is_comma || (comma_cnt == COMMA_W'(SYNC_CNT - 1))) comma_clr = 1'b1;
          else                                                    comma_inc = 1'b1;
        end
        ST_LOCKED: begin
          if (is_comma || (run_cnt == RUN_W'(MAX_RUN))) begin
            run_clr = 1'b1;
          end else begin
            run_inc = 1'b1;
            fwd     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      bitslip   <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      bitslip   <= slip_now;
      valid_out <= fwd;
      if (fwd) data_out <= byte_in;
    end
  end

  assign active = (state == ST_LOCKED);

  sync_sat_cnt #(.WIDTH(MISS_W), .MAX(MISS_W'(SLIP_TRIG))) u_miss_cnt (
    .clk_4f(clk_4f), .reset(reset), .clr(miss_clr), .inc(miss_inc), .count(miss_cnt)
  );

  sync_sat_cnt #(.WIDTH(COMMA_W), .MAX(COMMA_W'(SYNC_CNT))) u_comma_cnt (
    .clk_4f(clk_4f), .reset(reset), .clr(comma_clr), .inc(comma_inc), .count(comma_cnt)
  );

  sync_sat_cnt #(.WIDTH(RUN_W), .MAX(RUN_W'(MAX_RUN))) u_run_cnt (
    .clk_4f(clk_4f), .reset(reset), .clr(run_clr), .inc(run_inc), .count(run_cnt)
  );

  sync_sat_cnt #(.WIDTH(WAIT_W), .MAX(WAIT_W'(SLIP_WAIT))) u_wait_cnt (
    .clk_4f(clk_4f), .reset(reset), .clr(wait_clr), .inc(wait_inc), .count(wait_cnt)
  );

  sync_sat_cnt #(.WIDTH(SLIP_CNT_W), .MAX('1)) u_slip_cnt (
    .clk_4f(clk_4f), .reset(reset), .clr(1'b0), .inc(slip_inc), .count(slip_count)
  );

endmodule

// File: tb/tb_link_sync_ctrl.sv
// Directed self-checking bench for link_sync_ctrl with hand-computed expectations.
module tb_link_sync_ctrl;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       bitslip;
  logic       active;
  logic [7:0] data_out;
  logic       valid_out;
  logic [3:0] slip_count;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk_4f = ~clk_4f;

  link_sync_ctrl #(
    .COMMA(8'hBC), .SYNC_CNT(4), .SLIP_TRIG(8), .SLIP_WAIT(2), .MAX_RUN(32)
  ) dut (
    .clk_4f(clk_4f), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .bitslip(bitslip), .active(active), .data_out(data_out),
    .valid_out(valid_out), .slip_count(slip_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic v);
    @(negedge clk_4f);
    reset      = 1'b0;
    byte_in    = b;
    byte_valid = v;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_4f);
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    @(posedge clk_4f);
    #1;
    @(negedge clk_4f);
    reset = 1'b0;
  endtask

  // Four commas from SEARCH; active only after the fourth.
  task automatic lock_up(input string tag);
    for (int i = 1; i <= 4; i++) begin
      send(8'hBC, 1'b1);
      chk({tag, "_active"}, active, (i == 4));
      chk({tag, "_valid"}, valid_out, 0);
      chk({tag, "_bitslip"}, bitslip, 0);
    end
  endtask

  initial begin
    reset = 1'b1; byte_in = 8'h00; byte_valid = 1'b0;
    repeat (2) @(posedge clk_4f);
    #1;
    chk("rst_bitslip", bitslip, 0);
    chk("rst_active", active, 0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", valid_out, 0);
    chk("rst_slips", slip_count, 0);
    @(negedge clk_4f);
    reset = 1'b0;

    lock_up("lock");

    // Payload forwarding, one-cycle latency
    for (int i = 1; i <= 16; i++) begin
      send(8'(i), 1'b1);
      chk("fwd_valid", valid_out, 1);
      chk("fwd_data", data_out, i);
    end
    send(8'hBC, 1'b1);
    chk("comma_valid", valid_out, 0);
    chk("comma_data_hold", data_out, 8'h10);
    chk("comma_active", active, 1);

    send(8'h77, 1'b0);
    chk("idle_valid", valid_out, 0);
    chk("idle_data_hold", data_out, 8'h10);
    chk("idle_active", active, 1);

    // Run limit: 32 forwarded, 33rd dropped and lock lost
    for (int i = 1; i <= 33; i++) begin
      send(8'(8'h40 + i), 1'b1);
      if (i <= 32) begin
        chk("run_valid", valid_out, 1);
        chk("run_data", data_out, 8'h40 + i);
        chk("run_active", active, 1);
      end else begin
        chk("run33_valid", valid_out, 0);
        chk("run33_data_hold", data_out, 8'h60);
        chk("run33_active", active, 0);
      end
    end

    // Broken comma train restarts the count without a slip
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(8'hBC, 1'b1);
      chk("brk_active", active, 0);
    end
    send(8'h55, 1'b1);
    chk("brk55_active", active, 0);
    chk("brk55_bitslip", bitslip, 0);
    chk("brk55_valid", valid_out, 0);
    lock_up("relock");
    chk("relock_slips", slip_count, 0);

    // Reset while locked with a valid byte present
    send(8'h21, 1'b1);
    chk("pre_rst_valid", valid_out, 1);
    @(negedge clk_4f);
    reset = 1'b1; byte_valid = 1'b1; byte_in = 8'h01;
    @(posedge clk_4f);
    #1;
    chk("midrst_active", active, 0);
    chk("midrst_valid", valid_out, 0);
    chk("midrst_slips", slip_count, 0);
    chk("midrst_bitslip", bitslip, 0);
    chk("midrst_data", data_out, 8'h00);

    // Bit-slip after eight misses; an idle cycle in between changes nothing
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) begin
        send(8'hBC, 1'b0);
        chk("slip_idle_bitslip", bitslip, 0);
      end
      send(8'h3C, 1'b1);
      chk("slip_bitslip", bitslip, (i == 8));
      chk("slip_count", slip_count, (i == 8) ? 1 : 0);
    end
    send(8'hBC, 1'b1);
    chk("wait1_bitslip", bitslip, 0);
    chk("wait1_active", active, 0);
    send(8'hBC, 1'b1);
    chk("wait2_active", active, 0);
    lock_up("postslip");
    chk("postslip_slips", slip_count, 1);

    // slip_count saturates at 15
    do_reset();
    for (int s = 1; s <= 16; s++) begin
      for (int i = 0; i < 10; i++) send(8'h3C, 1'b1);
      chk("sat_slips", slip_count, (s > 15) ? 15 : s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
